// File: rtl/board_pkg.sv
// Board-wide constants shared by the chip-interface blocks.
// Debounce time is derived from the system clock so retargeting the board only touches CLOCK_HZ.
package board_pkg;

  localparam int CLOCK_HZ       = 50_000_000;
  localparam int DEBOUNCE_20MS  = CLOCK_HZ / 50;
  localparam bit KEY_ACTIVE_LOW = 1'b1;

  // Counter must be able to hold DEBOUNCE_CYCLES itself, hence the +1.
  function automatic int debounceCntWidth(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: polarity fix, synchroniser chain, debounce counter and registered edge pulses.
// Outputs are all driven straight from flops; the polarity XOR is the only logic ahead of the chain.
module debounce_channel
  import board_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter bit ACTIVE_LOW      = KEY_ACTIVE_LOW
) (
  input  logic clock,
  input  logic reset_L,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int                 CNT_W    = debounceCntWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   w_in;
  logic                   w_stable;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  assign w_in     = i_async ^ ACTIVE_LOW;
  assign w_stable = r_sync[SYNC_STAGES-1];

  // Any agreement with the accepted level, even for one cycle, restarts the count.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_stable == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_stable;
        r_cnt   <= '0;
        r_rise  <= w_stable;
        r_fall  <= ~w_stable;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel front end for asynchronous board pins: each bit gets its own independent
// debounce_channel, so events on different pins never interact.
module input_conditioner
  import board_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter bit ACTIVE_LOW      = KEY_ACTIVE_LOW
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be >= 2 (got %0d)", SYNC_STAGES);
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1 (got %0d)", DEBOUNCE_CYCLES);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clock  (clock),
      .reset_L(reset_L),
      .i_async(async_in[g]),
      .o_level(level[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with 2 channels, 2 sync stages, 4-cycle debounce, active-low pins.
// A level change on the pins shows up on the 6th rising edge after it was applied.
module tb_input_conditioner;

  logic       clock;
  logic       reset_L;
  logic [1:0] async_in;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .async_in(async_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Outputs are sampled 1 time unit after each rising edge, inputs change there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    async_in = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({level, rise, fall} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold edge %0d: level=%b rise=%b fall=%b, required all 0", k, level, rise, fall);
      end
    end
    reset_L = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (level !== ((k >= 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL reset_release_level edge %0d: got %b required %b", k, level, (k >= 6) ? 2'b11 : 2'b00);
      end
      checks++;
      if (rise !== ((k == 6) ? 2'b11 : 2'b00) || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_release_pulse edge %0d: rise=%b fall=%b required rise=%b fall=00", k, rise, fall, (k == 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_release_all();
    async_in = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (level !== ((k >= 6) ? 2'b00 : 2'b11)) begin
        errors++;
        $display("[TB] FAIL release_all_level edge %0d: got %b required %b", k, level, (k >= 6) ? 2'b00 : 2'b11);
      end
      checks++;
      if (fall !== ((k == 6) ? 2'b11 : 2'b00) || rise !== 2'b00) begin
        errors++;
        $display("[TB] FAIL release_all_pulse edge %0d: fall=%b rise=%b required fall=%b rise=00", k, fall, rise, (k == 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_clean_press();
    async_in = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (level !== ((k >= 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL press_level edge %0d: got %b required %b", k, level, (k >= 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (rise !== ((k == 6) ? 2'b01 : 2'b00) || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL press_pulse edge %0d: rise=%b fall=%b required rise=%b fall=00", k, rise, fall, (k == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_release();
    async_in = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (level !== ((k >= 6) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL release_level edge %0d: got %b required %b", k, level, (k >= 6) ? 2'b00 : 2'b01);
      end
      checks++;
      if (fall !== ((k == 6) ? 2'b01 : 2'b00) || rise !== 2'b00) begin
        errors++;
        $display("[TB] FAIL release_pulse edge %0d: fall=%b rise=%b required fall=%b rise=00", k, fall, rise, (k == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  // Three pressed cycles reach the synchroniser output, one short of acceptance, before the
  // bounce; the count then restarts and the press is accepted on edge 10.
  task automatic test_bounce();
    for (int k = 1; k <= 11; k++) begin
      async_in = (k == 4) ? 2'b11 : 2'b10;
      tick();
      checks++;
      if (rise !== ((k == 10) ? 2'b01 : 2'b00) || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL bounce_pulse edge %0d: rise=%b fall=%b required rise=%b fall=00", k, rise, fall, (k == 10) ? 2'b01 : 2'b00);
      end
      checks++;
      if (level !== ((k >= 10) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL bounce_level edge %0d: got %b required %b", k, level, (k >= 10) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_simultaneous();
    async_in = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (rise !== ((k == 6) ? 2'b11 : 2'b00) || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL simultaneous_pulse edge %0d: rise=%b fall=%b required rise=%b fall=00", k, rise, fall, (k == 6) ? 2'b11 : 2'b00);
      end
      checks++;
      if (level !== ((k >= 6) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL simultaneous_level edge %0d: got %b required %b", k, level, (k >= 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  // Channel 0 is released so its counter reaches 2 after the 4th edge; reset then wipes it.
  task automatic test_reset_mid_count();
    async_in = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (level !== 2'b11 || rise !== 2'b00 || fall !== 2'b00) begin
        errors++;
        $display("[TB] FAIL midcount_pre edge %0d: level=%b rise=%b fall=%b required level=11 rise=00 fall=00", k, level, rise, fall);
      end
    end
    reset_L = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if ({level, rise, fall} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL midcount_reset edge %0d: level=%b rise=%b fall=%b required all 0", k, level, rise, fall);
      end
    end
    reset_L  = 1'b1;
    async_in = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({level, rise, fall} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL midcount_after edge %0d: level=%b rise=%b fall=%b required all 0", k, level, rise, fall);
      end
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    async_in = 2'b00;
    test_reset();
    test_release_all();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
